alpha_mem_sched: RTL and testbench

ALPHA_MEM_SCHED -- requirements
Module: alpha_mem_sched

---
 rtl/alpha_mem_sched_if.sv | 28 ++
 rtl/alpha_mem_sched.sv | 113 +++++++++++
 tb/tb_alpha_mem_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alpha_mem_sched_if.sv
// Handshake bundle between the alpha scheduler, the forward-recursion unit
// and the LLR unit.
interface alpha_mem_sched_if;
    logic       alpha_valid;
    logic       alpha_ready;
    logic       rd_req;
    logic       rd_ready;
    logic       rd_valid;
    logic [3:0] rd_step;

    modport master (
        output alpha_valid,
        output rd_req,
        input  alpha_ready,
        input  rd_ready,
        input  rd_valid,
        input  rd_step
    );

    modport slave (
        input  alpha_valid,
        input  rd_req,
        output alpha_ready,
        output rd_ready,
        output rd_valid,
        output rd_step
    );
endinterface

// File: rtl/alpha_mem_sched.sv
// Alpha SRAM scheduler: stores forward metrics per trellis step, then
// replays them in reverse order for the LLR unit.
module alpha_mem_sched #(
    parameter int STEPS      = 9,
    parameter int addr_width = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    alpha_mem_sched_if.slave      bus,
    input  logic                  start,
    input  logic [3:0]            frame_len,
    output logic                  sram_write_read,
    output logic [addr_width:0]   sram_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int         AW      = addr_width + 1;
    localparam logic [3:0] MAX_LEN = 4'(STEPS);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t     state;
    logic [3:0] len;
    logic [3:0] wr_step;
    logic [3:0] rd_ptr;
    logic       wr_fire;
    logic       rd_fire;
    logic       len_ok;

    assign wr_fire = (state == WRITE) && bus.alpha_valid;
    assign rd_fire = (state == READ) && bus.rd_req;
    assign len_ok  = (frame_len != 4'd0) && (frame_len <= MAX_LEN);

    // SRAM strobes are combinational so the access lands in the request cycle
    always_comb begin
        sram_write_read = wr_fire;
        sram_addr       = '0;
        if (wr_fire)
            sram_addr = AW'({wr_step, 3'b000});
        else if (rd_fire)
            sram_addr = AW'({rd_ptr, 3'b000});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            len             <= '0;
            wr_step         <= '0;
            rd_ptr          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            bus.alpha_ready <= 1'b0;
            bus.rd_ready    <= 1'b0;
            bus.rd_valid    <= 1'b0;
            bus.rd_step     <= '0;
        end else begin
            done         <= 1'b0;
            err          <= 1'b0;
            bus.rd_valid <= rd_fire;
            if (rd_fire)
                bus.rd_step <= rd_ptr;
            unique case (state)
                IDLE: begin
                    if (start && len_ok) begin
                        len             <= frame_len;
                        wr_step         <= '0;
                        busy            <= 1'b1;
                        bus.alpha_ready <= 1'b1;
                        state           <= WRITE;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.alpha_valid) begin
                        wr_step <= wr_step + 4'd1;
                        if (wr_step == len - 4'd1) begin
                            rd_ptr          <= len - 4'd1;
                            bus.alpha_ready <= 1'b0;
                            bus.rd_ready    <= 1'b1;
                            state           <= READ;
                        end
                    end
                end
                READ: begin
                    if (bus.rd_req) begin
                        if (rd_ptr == 4'd0) begin
                            bus.rd_ready <= 1'b0;
                            done         <= 1'b1;
                            state        <= DRAIN;
                        end else begin
                            rd_ptr <= rd_ptr - 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alpha_mem_sched.sv
// Scoreboard bench for alpha_mem_sched with a behavioural 1-cycle SRAM.
module tb_alpha_mem_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] frame_len = 4'd0;
    logic       sram_write_read;
    logic [7:0] sram_addr;
    logic       busy;
    logic       done;
    logic       err;

    alpha_mem_sched_if bus();

    alpha_mem_sched #(.STEPS(9), .addr_width(7)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .start           (start),
        .frame_len       (frame_len),
        .sram_write_read (sram_write_read),
        .sram_addr       (sram_addr),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  step;
        logic [63:0] data;
    } rd_exp_t;

    rd_exp_t     rq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        exp_wr  = 1'b0;
    logic [63:0] wdata   = '0;
    logic [63:0] out_data;
    logic [63:0] mem [0:8];

    // behavioural SRAM, one vector of 8 metrics per step
    always @(posedge clk) begin
        int idx;
        idx = int'(sram_addr >> 3);
        if (idx < 9) begin
            if (sram_write_read === 1'b1)
                mem[idx] <= wdata;
            else
                out_data <= mem[idx];
        end
    end

    function automatic logic [63:0] pat(input logic [7:0] tag,
                                        input logic [3:0] s);
        return {8{tag ^ {4'h0, s}}} ^ 64'h0123_4567_89ab_cdef;
    endfunction

    // monitor: write strobe, address ceiling, read-return scoreboard
    always @(negedge clk) begin
        if (rst) begin
            n_tests++;
            if (sram_write_read !== exp_wr) begin
                n_fail++;
                $display("FAIL wr_strobe got %b want %b t=%0t",
                         sram_write_read, exp_wr, $time);
            end
            if (sram_write_read === 1'b1) begin
                n_tests++;
                if (sram_addr > 8'd64) begin
                    n_fail++;
                    $display("FAIL addr_max got %0d want <=64", sram_addr);
                end
            end
            if (bus.rd_valid === 1'b1) begin
                n_tests++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rd_valid got 1 want 0 t=%0t", $time);
                end else begin
                    rd_exp_t e;
                    e = rq.pop_front();
                    if (bus.rd_step !== e.step || out_data !== e.data) begin
                        n_fail++;
                        $display("FAIL rd_data got %0d/%h want %0d/%h",
                                 bus.rd_step, out_data, e.step, e.data);
                    end
                end
            end
        end
    end

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input int len, input bit wgap,
                            input bit rgap, input logic [7:0] tag);
        int k;
        int p;
        bit ph;
        go();
        start     = 1'b1;
        frame_len = 4'(len);
        go();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || bus.alpha_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_accept got %b%b want 11",
                     busy, bus.alpha_ready);
        end
        k  = 0;
        ph = 1'b0;
        while (k < len) begin
            if (wgap && ph) begin
                bus.alpha_valid = 1'b0;
                exp_wr          = 1'b0;
            end else begin
                bus.alpha_valid = 1'b1;
                wdata           = pat(tag, 4'(k));
                exp_wr          = 1'b1;
                #1;
                n_tests++;
                if (sram_addr !== 8'(k * 8)) begin
                    n_fail++;
                    $display("FAIL wr_addr got %0d want %0d",
                             sram_addr, k * 8);
                end
                k++;
            end
            ph = !ph;
            go();
        end
        bus.alpha_valid = 1'b1;
        exp_wr          = 1'b0;
        wdata           = '1;
        n_tests++;
        if (bus.rd_ready !== 1'b1 || bus.alpha_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_entry got %b%b want 10",
                     bus.rd_ready, bus.alpha_ready);
        end
        p  = len - 1;
        ph = 1'b0;
        while (p >= 0) begin
            start = 1'b0;
            if (rgap && ph) begin
                bus.rd_req = 1'b0;
                start      = 1'b1;
                frame_len  = 4'd0;
                go();
                start = 1'b0;
                n_tests++;
                if (err !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_in_read got %b%b want 01",
                             err, busy);
                end
            end else begin
                bus.rd_req = 1'b1;
                rq.push_back('{step: 4'(p), data: pat(tag, 4'(p))});
                #1;
                n_tests++;
                if (sram_addr !== 8'(p * 8)) begin
                    n_fail++;
                    $display("FAIL rd_addr got %0d want %0d",
                             sram_addr, p * 8);
                end
                p--;
                go();
            end
            ph = !ph;
        end
        bus.rd_req      = 1'b0;
        bus.alpha_valid = 1'b0;
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b1 || bus.rd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain got %b%b%b want 110",
                     done, busy, bus.rd_ready);
        end
        go();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL idle_return got %b%b/%0d want 00/0",
                     done, busy, rq.size());
        end
    endtask

    task automatic test_reset();
        bus.alpha_valid = 1'b0;
        bus.rd_req      = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, err, bus.rd_valid, bus.alpha_ready,
             bus.rd_ready, sram_write_read} !== 7'b0 ||
            sram_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state got %b%b%b%b%b%b%b/%0d want 0",
                     busy, done, err, bus.rd_valid, bus.alpha_ready,
                     bus.rd_ready, sram_write_read, sram_addr);
        end
        @(negedge clk);
        rst       = 1'b1;
        start     = 1'b1;
        frame_len = 4'd3;
        go();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || bus.alpha_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL first_edge_start got %b%b want 11",
                     busy, bus.alpha_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || bus.alpha_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b%b want 00",
                     busy, bus.alpha_ready);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        do_frame(4, 1'b0, 1'b0, 8'h11);
    endtask

    task automatic test_len9();
        do_frame(9, 1'b1, 1'b0, 8'h52);
    endtask

    task automatic test_illegal();
        logic [3:0] bad [2];
        bad[0] = 4'd0;
        bad[1] = 4'd10;
        for (int i = 0; i < 2; i++) begin
            go();
            start     = 1'b1;
            frame_len = bad[i];
            go();
            start = 1'b0;
            n_tests++;
            if (err !== 1'b1 || busy !== 1'b0 || bus.alpha_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL err_pulse len=%0d got %b%b%b want 100",
                         bad[i], err, busy, bus.alpha_ready);
            end
            go();
            n_tests++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL err_clear got %b%b want 00", err, busy);
            end
        end
    endtask

    task automatic test_ignore();
        go();
        bus.alpha_valid = 1'b1;
        bus.rd_req      = 1'b1;
        exp_wr          = 1'b0;
        go();
        go();
        n_tests++;
        if (bus.rd_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore got %b%b want 00",
                     bus.rd_ready, busy);
        end
        bus.alpha_valid = 1'b0;
        bus.rd_req      = 1'b0;
    endtask

    task automatic test_mid_reset();
        go();
        start     = 1'b1;
        frame_len = 4'd5;
        go();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.alpha_valid = 1'b1;
            wdata           = pat(8'h77, 4'(i));
            exp_wr          = 1'b1;
            go();
        end
        bus.alpha_valid = 1'b0;
        exp_wr          = 1'b0;
        rst             = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, bus.alpha_ready, sram_write_read} !== 4'b0 ||
            sram_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset got %b%b%b%b/%0d want 0",
                     busy, done, bus.alpha_ready, sram_write_read,
                     sram_addr);
        end
        go();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_done got %b want 0", done);
        end
        @(negedge clk);
        rst = 1'b1;
        do_frame(2, 1'b0, 1'b0, 8'h2c);
    endtask

    task automatic test_gap_start();
        do_frame(3, 1'b0, 1'b1, 8'h93);
        do_frame(1, 1'b0, 1'b0, 8'h0e);
    endtask

    task automatic test_back_to_back();
        do_frame(3, 1'b0, 1'b0, 8'h41);
        do_frame(2, 1'b1, 1'b1, 8'hd6);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.alpha_valid = 1'b0;
        bus.rd_req      = 1'b0;
        test_reset();
        test_basic();
        test_len9();
        test_illegal();
        test_ignore();
        test_mid_reset();
        test_gap_start();
        test_back_to_back();
        go();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
